// File: rtl/bn_rsqrt_seq.sv
// rtl/bn_rsqrt_seq.sv - sequential fp16 1/sqrt(x) controller driving an external Newton-step datapath
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid/in_ready/in_data operand handshake (fp16 x = variance + eps)
//   out_valid/out_ready      result handshake
//   out_data                 fp16 1/sqrt(x), 16'h7E00 when out_err
//   out_err                  operand negative, zero/subnormal, inf or NaN
//   out_timeout              MAX_ITER steps used without reaching a fixed point
//   out_iter                 number of Newton steps used
//   dp_x, dp_y               operand and current estimate to the datapath
//   dp_y_next                datapath result y*(1.5-0.5*x*y*y)
//
// Build option: BN_RSQRT_SEQ_SEED_EN selects an exponent-derived seed
// instead of the constant seed 1.0.

module bn_rsqrt_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_ITER   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_err,
    output logic                  out_timeout,
    output logic [3:0]            out_iter,
    output logic [DATA_WIDTH-1:0] dp_x,
    output logic [DATA_WIDTH-1:0] dp_y,
    input  logic [DATA_WIDTH-1:0] dp_y_next
);

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    localparam logic [3:0]            MAX_ITER_L = 4'(MAX_ITER);
    localparam logic [DATA_WIDTH-1:0] ONE_FP16   = 16'h3C00;
    localparam logic [DATA_WIDTH-1:0] QNAN_FP16  = 16'h7E00;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] x_q, x_d;
    logic [DATA_WIDTH-1:0] y_q, y_d;
    logic [3:0]            iter_q, iter_d;
    logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
    logic                  res_err_q, res_err_d;
    logic                  res_to_q, res_to_d;
    logic [3:0]            res_iter_q, res_iter_d;

    logic [DATA_WIDTH-1:0] seed;
    logic                  illegal;
    logic [3:0]            iter_inc;

`ifdef BN_RSQRT_SEQ_SEED_EN
    // 1/sqrt(2^(e-15)) = 2^((15-e)/2); biased result exponent is (45-e)/2.
    logic [5:0] seed_diff;
    assign seed_diff = 6'd45 - {1'b0, in_data[14:10]};
    assign seed      = {1'b0, seed_diff[5:1], 10'b0};
`else
    assign seed = ONE_FP16;
`endif

    assign illegal  = in_data[15] || (in_data[14:10] == 5'd0) || (in_data[14:10] == 5'd31);
    assign iter_inc = iter_q + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= ONE_FP16;
            iter_q     <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
            res_to_q   <= 1'b0;
            res_iter_q <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            iter_q     <= iter_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
            res_to_q   <= res_to_d;
            res_iter_q <= res_iter_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        iter_d     = iter_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
        res_to_d   = res_to_q;
        res_iter_d = res_iter_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d    = in_data;
                    y_d    = seed;
                    iter_d = '0;
                    if (illegal) begin
                        // Datapath is skipped entirely for illegal operands.
                        state_d    = DONE;
                        res_data_d = QNAN_FP16;
                        res_err_d  = 1'b1;
                        res_to_d   = 1'b0;
                        res_iter_d = '0;
                    end else begin
                        state_d = ITER;
                    end
                end
            end
            ITER: begin
                y_d    = dp_y_next;
                iter_d = iter_inc;
                // A fixed point wins even on the last allowed step.
                if (dp_y_next == y_q) begin
                    state_d    = DONE;
                    res_data_d = dp_y_next;
                    res_err_d  = 1'b0;
                    res_to_d   = 1'b0;
                    res_iter_d = iter_inc;
                end else if (iter_inc == MAX_ITER_L) begin
                    state_d    = DONE;
                    res_data_d = dp_y_next;
                    res_err_d  = 1'b0;
                    res_to_d   = 1'b1;
                    res_iter_d = MAX_ITER_L;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign out_data    = res_data_q;
    assign out_err     = res_err_q;
    assign out_timeout = res_to_q;
    assign out_iter    = res_iter_q;
    assign dp_x        = x_q;
    assign dp_y        = y_q;

endmodule

// File: tb/tb_bn_rsqrt_seq.sv
// tb/tb_bn_rsqrt_seq.sv - self-checking bench for bn_rsqrt_seq

module tb_bn_rsqrt_seq;

    localparam int MAX_IT = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        out_err;
    logic        out_timeout;
    logic [3:0]  out_iter;
    logic [15:0] dp_x;
    logic [15:0] dp_y;
    logic [15:0] dp_y_next;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;

    // datapath model: 0 = constant, 1 = alternate 3800/3A00, 2 = step down to target
    int          dp_mode = 0;
    logic [15:0] dp_c = 16'h3C00;
    logic [15:0] dp_tgt = 16'h3C00;

    bn_rsqrt_seq #(.DATA_WIDTH(16), .MAX_ITER(MAX_IT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_err(out_err), .out_timeout(out_timeout), .out_iter(out_iter),
        .dp_x(dp_x), .dp_y(dp_y), .dp_y_next(dp_y_next)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] step(input int mode, input logic [15:0] c,
                                         input logic [15:0] tgt, input logic [15:0] y);
        if (mode == 0) return c;
        if (mode == 1) return (y == 16'h3800) ? 16'h3A00 : 16'h3800;
        return (y > tgt) ? y - 16'h0100 : y;
    endfunction

    always_comb dp_y_next = step(dp_mode, dp_c, dp_tgt, dp_y);

    function automatic logic [15:0] seed_of(input logic [15:0] x);
`ifdef BN_RSQRT_SEQ_SEED_EN
        int e;
        int s;
        e = int'(x[14:10]);
        s = (45 - e) / 2;
        return {1'b0, 5'(s), 10'b0};
`else
        return 16'h3C00;
`endif
    endfunction

    task automatic model(input logic [15:0] x, input int mode, input logic [15:0] c,
                         input logic [15:0] tgt, output logic [15:0] d, output logic e,
                         output logic to, output logic [3:0] it, output int lat);
        logic [15:0] y;
        logic [15:0] yn;
        d = '0; e = 1'b0; to = 1'b0; it = '0; lat = 0;
        if (x[15] || x[14:10] == 5'd0 || x[14:10] == 5'd31) begin
            d = 16'h7E00; e = 1'b1; lat = 1;
            return;
        end
        y = seed_of(x);
        for (int k = 1; k <= MAX_IT; k++) begin
            yn = step(mode, c, tgt, y);
            if (yn == y) begin
                d = yn; it = 4'(k); lat = k + 1;
                return;
            end
            y = yn;
        end
        d = y; to = 1'b1; it = 4'(MAX_IT); lat = MAX_IT + 1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // scoreboard state for the compare process
    logic        pending = 1'b0;
    int          acc_cyc = 0;
    logic [15:0] exp_x = '0;
    logic [15:0] e_data;
    logic        e_err;
    logic        e_to;
    logic [3:0]  e_iter;
    int          e_lat;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_in_ready", in_ready, 1);
            check("rst_out_valid", out_valid, 0);
            check("rst_out_data", out_data, 0);
            check("rst_out_err", out_err, 0);
            check("rst_out_timeout", out_timeout, 0);
            check("rst_out_iter", out_iter, 0);
            check("rst_dp_x", dp_x, 0);
            check("rst_dp_y", dp_y, 16'h3C00);
            pending = 1'b0;
            exp_x   = '0;
        end else begin
            check("in_ready", in_ready, !pending);
            check("dp_x", dp_x, exp_x);
            check("out_valid", out_valid, pending && (cyc - acc_cyc >= e_lat));
            if (pending && !e_err && cyc == acc_cyc + 1)
                check("dp_y_seed", dp_y, seed_of(exp_x));
            if (out_valid && pending) begin
                check("out_data", out_data, e_data);
                check("out_err", out_err, e_err);
                check("out_timeout", out_timeout, e_to);
                check("out_iter", out_iter, e_iter);
                if (e_err) check("dp_y_unused", dp_y, seed_of(exp_x));
                if (out_ready) pending = 1'b0;
            end
            if (in_valid && in_ready) begin
                model(in_data, dp_mode, dp_c, dp_tgt, e_data, e_err, e_to, e_iter, e_lat);
                exp_x   = in_data;
                acc_cyc = cyc;
                pending = 1'b1;
            end
        end
    end

    task automatic timeout_fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: wait bound expired, got no event expected event", name);
    endtask

    task automatic op(input logic [15:0] x, input int hold);
        int b;
        @(posedge clk); #1;
        b = 0;
        while (!in_ready && b < 50) begin @(posedge clk); #1; b++; end
        if (b >= 50) timeout_fail("wait_in_ready");
        in_valid  = 1'b1;
        in_data   = x;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        b = 0;
        while (!out_valid && b < 40) begin @(posedge clk); #1; b++; end
        if (b >= 40) timeout_fail("wait_out_valid");
        for (int i = 0; i < hold; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = 16'($urandom);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1);
    end

    initial begin
        logic [15:0] d;
        logic        e;
        logic        to;
        logic [3:0]  it;
        int          lat;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // hand-computed pins of the reference model (constant-seed build)
`ifndef BN_RSQRT_SEQ_SEED_EN
        model(16'h3C00, 0, 16'h3C00, 16'h0, d, e, to, it, lat);
        check("pin_conv_data", d, 16'h3C00);
        check("pin_conv_iter", it, 1);
        check("pin_conv_lat", lat, 2);
        model(16'h3C00, 1, 16'h0, 16'h0, d, e, to, it, lat);
        check("pin_alt_data", d, 16'h3A00);
        check("pin_alt_to", to, 1);
        check("pin_alt_lat", lat, 9);
        model(16'h4000, 2, 16'h0, 16'h3900, d, e, to, it, lat);
        check("pin_step_iter", it, 4);
        check("pin_step_data", d, 16'h3900);
        model(16'h3E00, 2, 16'h0, 16'h3500, d, e, to, it, lat);
        check("pin_edge_iter", it, 8);
        check("pin_edge_to", to, 0);
`else
        model(16'h4400, 0, 16'h3800, 16'h0, d, e, to, it, lat);
        check("pin_seed_data", d, 16'h3800);
        check("pin_seed_iter", it, 1);
        check("pin_seed_4400", seed_of(16'h4400), 16'h3800);
`endif
        model(16'hBC00, 0, 16'h3C00, 16'h0, d, e, to, it, lat);
        check("pin_neg_data", d, 16'h7E00);
        check("pin_neg_lat", lat, 1);

        dp_mode = 0; dp_c = 16'h3C00;
        op(16'h3C00, 0);
        op(16'hBC00, 0);
        op(16'h0000, 0);
        op(16'h7C00, 0);
        dp_mode = 1;
        op(16'h3C00, 0);
        dp_mode = 2; dp_tgt = 16'h3900;
        op(16'h4000, 0);
        dp_tgt = 16'h3500;
        op(16'h3E00, 0);
        dp_mode = 0; dp_c = 16'h3800;
        op(16'h4400, 0);
        dp_c = 16'h3C00;
        op(16'h3C00, 5);

        // reset during the third ITER cycle of a long operation
        dp_mode = 1;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 16'h3C00;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        dp_mode = 0; dp_c = 16'h3C00;
        op(16'h3C00, 0);
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bn_rsqrt_seq.md
BN_RSQRT_SEQ -- requirements
Module: bn_rsqrt_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, fp16 operand/result width (only 16 supported).
REQ-002 SHALL have parameter MAX_ITER, default 8, maximum iteration cycles per operation, legal 1..15.
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1: request carries operand.
REQ-006 SHALL have port in_ready, output, 1: controller accepts operand.
REQ-007 SHALL have port in_data, input, 16: fp16 operand x (variance+eps).
REQ-008 SHALL have port out_valid, output, 1: result available.
REQ-009 SHALL have port out_ready, input, 1: consumer takes result.
REQ-010 SHALL have port out_data, output, 16: fp16 1/sqrt(x).
REQ-011 SHALL have port out_err, output, 1: operand illegal, out_data is NaN.
REQ-012 SHALL have port out_timeout, output, 1: MAX_ITER reached without convergence.
REQ-013 SHALL have port out_iter, output, 4: iteration cycles used.
REQ-014 SHALL have port dp_x, output, 16: operand to external Newton-step datapath.
REQ-015 SHALL have port dp_y, output, 16: current estimate to datapath.
REQ-016 SHALL have port dp_y_next, input, 16: combinational next estimate y*(1.5-0.5*x*y*y) from datapath.

Function
REQ-017 SHALL implement FSM states IDLE, ITER, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-018 In IDLE, on in_valid&&in_ready, SHALL latch x<=in_data, y<=seed, iter<=0.
REQ-019 On accept, if in_data sign=1, exponent=0 (zero/subnormal) or exponent=31 (inf/NaN), SHALL go to DONE with out_data=16'h7E00, out_err=1, out_timeout=0, out_iter=0; datapath unused.
REQ-020 On accept of a legal operand SHALL go to ITER.
REQ-021 Each ITER cycle SHALL register y<=dp_y_next and iter<=iter+1.
REQ-022 In ITER, if dp_y_next==y (bitwise), SHALL go to DONE with out_data=dp_y_next, out_timeout=0, out_iter=iter+1.
REQ-023 Otherwise, if iter+1==MAX_ITER, SHALL go to DONE with out_data=dp_y_next, out_timeout=1, out_iter=MAX_ITER.
REQ-024 Convergence SHALL take priority over timeout when both hold in the same cycle.
REQ-025 dp_x SHALL equal latched x and dp_y SHALL equal register y in all states.
REQ-026 In DONE, out_data/out_err/out_timeout/out_iter SHALL hold stable until out_valid&&out_ready; then SHALL return to IDLE.
REQ-027 No bypass: in_ready SHALL be 0 in the DONE handshake cycle; earliest next accept is the following cycle.
REQ-028 Latency, legal operand: out_valid asserts k+1 cycles after accept edge, k = iterations used (1..MAX_ITER).
REQ-029 in_data SHALL be ignored outside IDLE.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, in_ready=1, out_valid=0, out_data=0, out_err=0, out_timeout=0, out_iter=0, x=0, y=16'h3C00.
REQ-031 Reset mid-ITER or mid-DONE SHALL discard the operation; no result is produced after release.

Configuration
REQ-032 Macro BN_RSQRT_SEQ_SEED_EN defined: seed = {1'b0, ((45-e)>>1) as 5 bits, 10'b0}, e = in_data exponent field.
REQ-033 Macro undefined: seed = 16'h3C00 (1.0) for every operand; all other behaviour identical.

Verification
REQ-034 Macro undefined, x=16'h3C00, datapath model returns 3C00 -> out_valid 2 cycles after accept, out_data=3C00, out_iter=1, out_timeout=0.
REQ-035 x=16'hBC00 and x=16'h0000 -> out_valid 1 cycle after accept, out_data=7E00, out_err=1, out_iter=0, dp_y never updated.
REQ-036 MAX_ITER=8, datapath model alternating 3800/3A00 -> out_timeout=1, out_iter=8, out_valid 9 cycles after accept.
REQ-037 Macro defined, x=16'h4400 (4.0) -> dp_y=16'h3800 first ITER cycle; model returns 3800 -> out_data=3800, out_iter=1.
REQ-038 out_ready low 5 cycles in DONE -> outputs stable, in_ready=0, in_valid pulses ignored; handshake then IDLE next cycle.
REQ-039 rst_n asserted on 3rd ITER cycle -> same-cycle IDLE reset values, no out_valid after release; next operation completes normally.
